cic_ctrl: RTL

Sequencing controller for the CIC decimation filter in the DFE receive chain. Accepts configuration updates for enable, bypass and decimation factor, and applies each one safely: it stalls the filter, clears its integrator/comb state, refills the pipeline, then resumes. It also produces the decimated-output valid strobe, so downstream blocks sample `y_n` exactly once per output sample. It sits between the register/APB configuration space and the CIC `EN`/`bypass`/`Decimation_Factor` inputs.

---
 rtl/cic_ctrl_pkg.sv | 20 ++
 rtl/cic_ctrl_if.sv | 38 +++
 rtl/cic_ctrl_phase_cnt.sv | 28 ++
 rtl/cic_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC sequencing controller.
package cic_ctrl_pkg;

  localparam int DEC_MAX = 4;
  localparam int DEC_W   = 3;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_RUN
  } state_e;

  // Decimation factor D = 1 << log2(D); legal dec (0..4) fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] dec_factor(input logic [DEC_W-1:0] dec);
    return CNT_W'(1) << dec;
  endfunction

endpackage

// File: rtl/cic_ctrl_if.sv
// Configuration/status bundle between the config space, cic_ctrl and the CIC filter.
// CIC_CTRL_STATUS_EN adds the sample_cnt status signal.
interface cic_ctrl_if;
  import cic_ctrl_pkg::*;

  logic             cfg_wr;
  logic [DEC_W-1:0] cfg_dec;
  logic             cfg_bypass;
  logic             cfg_en;
  logic             in_valid;
  logic             cfg_busy;
  logic             cfg_err;
  logic             cic_en;
  logic             cic_bypass;
  logic [DEC_W-1:0] cic_dec;
  logic             cic_clr;
  logic             out_valid;
`ifdef CIC_CTRL_STATUS_EN
  logic [15:0]      sample_cnt;
`endif

  modport master (
    output cfg_wr, cfg_dec, cfg_bypass, cfg_en, in_valid,
`ifdef CIC_CTRL_STATUS_EN
    input  sample_cnt,
`endif
    input  cfg_busy, cfg_err, cic_en, cic_bypass, cic_dec, cic_clr, out_valid
  );

  modport slave (
    input  cfg_wr, cfg_dec, cfg_bypass, cfg_en, in_valid,
`ifdef CIC_CTRL_STATUS_EN
    output sample_cnt,
`endif
    output cfg_busy, cfg_err, cic_en, cic_bypass, cic_dec, cic_clr, out_valid
  );

endinterface

// File: rtl/cic_ctrl_phase_cnt.sv
// cic_phase_cnt: 5-bit counter with programmable wrap value and terminal-count pulse.
module cic_phase_cnt
  import cic_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] wrap_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = inc_i && (cnt_q == wrap_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) cnt_d = '0;
    else if (inc_i)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cic_ctrl.sv
// CIC sequencing controller: shadow config, IDLE/CLEAR/FILL/RUN flush FSM, decimated valid strobe.
// Define CIC_CTRL_STATUS_EN to add the 16-bit output sample counter.
module cic_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int LAT        = 4,
  parameter int BYP_LAT    = 1,
  parameter int CLR_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  cic_ctrl_if.slave bus
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_e           state_q;
  logic             en_q, byp_q, err_q;
  logic [DEC_W-1:0] dec_q;
  logic [CLR_W-1:0] clr_cnt_q;
  logic [BYP_LAT:1] dly_q;

  logic             dec_ok, wr_ok, go_clr, live, en_w, in_clr;
  logic             fill_inc, fill_tc, ph_inc, ph_tc, ov;
  logic [CNT_W-1:0] fill_wrap, ph_wrap;

  assign dec_ok = bus.cfg_dec <= DEC_W'(DEC_MAX);
  assign wr_ok  = bus.cfg_wr && dec_ok;
  assign go_clr = wr_ok && bus.cfg_en;
  assign live   = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign en_w   = live && en_q && bus.in_valid;
  assign in_clr = (state_q == ST_CLEAR);

  // Bypassed filter has a fixed cycle latency, so fill counts cycles instead of samples.
  // Otherwise the transition pulse lands on the first valid after LAT+D accepted samples.
  assign fill_inc  = (state_q == ST_FILL) && (byp_q || bus.in_valid);
  assign fill_wrap = byp_q ? CNT_W'(BYP_LAT - 1) : CNT_W'(LAT) + dec_factor(dec_q);
  assign ph_inc    = (state_q == ST_RUN) && !byp_q && bus.in_valid;
  assign ph_wrap   = dec_factor(dec_q) - CNT_W'(1);

  cic_phase_cnt u_fill (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (in_clr),
    .inc_i  (fill_inc),
    .wrap_i (fill_wrap),
    .tc_o   (fill_tc)
  );

  cic_phase_cnt u_phase (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (in_clr),
    .inc_i  (ph_inc),
    .wrap_i (ph_wrap),
    .tc_o   (ph_tc)
  );

  // An accepted write restarts the sequence, so the old configuration never emits on that cycle.
  always_comb begin
    ov = 1'b0;
    if (byp_q) ov = (state_q == ST_RUN) && dly_q[BYP_LAT];
    else       ov = ((state_q == ST_FILL) && fill_tc) || ph_tc;
    if (wr_ok) ov = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      byp_q     <= 1'b0;
      dec_q     <= '0;
      err_q     <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      err_q <= bus.cfg_wr && !dec_ok;
      if (wr_ok) begin
        en_q      <= bus.cfg_en;
        byp_q     <= bus.cfg_bypass;
        dec_q     <= bus.cfg_dec;
        clr_cnt_q <= '0;
        state_q   <= bus.cfg_en ? ST_CLEAR : ST_IDLE;
      end else begin
        case (state_q)
          ST_CLEAR: begin
            if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) state_q <= ST_FILL;
            else clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
          ST_FILL:  if (fill_tc) state_q <= ST_RUN;
          default:  ;
        endcase
      end
    end
  end

  // Bypass valid delay line; dly_q[k] is cic_en from k cycles ago.
  always_ff @(posedge clk) begin
    if (rst || in_clr) begin
      dly_q <= '0;
    end else begin
      dly_q[1] <= en_w;
      for (int i = 2; i <= BYP_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

`ifdef CIC_CTRL_STATUS_EN
  logic [15:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (go_clr)  smp_d = '0;
    else if (ov) smp_d = smp_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) smp_q <= '0;
    else     smp_q <= smp_d;
  end

  assign bus.sample_cnt = smp_q;
`endif

  assign bus.cfg_busy   = in_clr || (state_q == ST_FILL);
  assign bus.cfg_err    = err_q;
  assign bus.cic_en     = en_w;
  assign bus.cic_bypass = byp_q;
  assign bus.cic_dec    = dec_q;
  assign bus.cic_clr    = in_clr;
  assign bus.out_valid  = ov;

endmodule
